// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment path: segment bit order, digit
// patterns, the read-back FSM state type and the x10 helper.
package seg7_pkg;

  // Bit positions inside seg[6:0] = {g,f,e,d,c,b,a}; 1 = segment lit.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIG_H = 3'd1,
    DIG_T = 3'd2,
    DIG_O = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Shift-and-add x10; 999 is the largest result, so 10 bits never wrap.
  function automatic logic [9:0] times_ten(input logic [9:0] v);
    return (v << 3) + (v << 1);
  endfunction

endpackage

// File: rtl/seven_seg_to_binary_if.sv
// Input/output handshake bundle for the seven-segment read-back decoder.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid, once raised, holds its payload stable until that edge.
interface seven_seg_to_binary_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] seg_hundreds;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] binary_out;
  logic       err_invalid;
  logic       err_overflow;

  modport master (
    output in_valid, seg_hundreds, seg_tens, seg_ones, out_ready,
    input  in_ready, out_valid, binary_out, err_invalid, err_overflow
  );

  modport slave (
    input  in_valid, seg_hundreds, seg_tens, seg_ones, out_ready,
    output in_ready, out_valid, binary_out, err_invalid, err_overflow
  );
endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational seven-segment pattern to decimal digit decoder.
// Blank reads as 0; any unknown pattern reads as 0 and raises invalid.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       invalid
);

  always_comb begin
    digit   = 4'd0;
    invalid = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = 4'd0;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_to_binary.sv
// Reads three seven-segment digits back into an 8-bit value, one digit per
// cycle through a x10 accumulator, with invalid-pattern and overflow flags.
module seven_seg_to_binary
  import seg7_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  seven_seg_to_binary_if.slave  bus,
  output state_t                dbg_state
);

  state_t     state, state_next;
  logic [6:0] cap_h, cap_t, cap_o;
  logic [9:0] acc;
  logic       err_seen;
  logic [7:0] res_bin;
  logic       res_inv;
  logic       res_ovf;

  logic [6:0] sel_pat;
  logic [3:0] digit;
  logic       dig_inv;
  logic [9:0] acc_next;
  logic       err_next;

  // One shared decoder; the state picks which captured digit it sees.
  always_comb begin
    sel_pat = cap_o;
    case (state)
      DIG_H:   sel_pat = cap_h;
      DIG_T:   sel_pat = cap_t;
      default: sel_pat = cap_o;
    endcase
  end

  seg7_digit_decode u_decode (
    .pattern (sel_pat),
    .digit   (digit),
    .invalid (dig_inv)
  );

  assign acc_next = times_ten(acc) + {6'd0, digit};
  assign err_next = err_seen | dig_inv;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = DIG_H;
      DIG_H:   state_next = DIG_T;
      DIG_T:   state_next = DIG_O;
      DIG_O:   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cap_h    <= 7'd0;
      cap_t    <= 7'd0;
      cap_o    <= 7'd0;
      acc      <= 10'd0;
      err_seen <= 1'b0;
      res_bin  <= 8'h00;
      res_inv  <= 1'b0;
      res_ovf  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cap_h    <= bus.seg_hundreds;
            cap_t    <= bus.seg_tens;
            cap_o    <= bus.seg_ones;
            acc      <= 10'd0;
            err_seen <= 1'b0;
          end
        end
        DIG_H, DIG_T: begin
          acc      <= acc_next;
          err_seen <= err_next;
        end
        DIG_O: begin
          acc      <= acc_next;
          err_seen <= err_next;
          // Resolve from the final sum so flags land with out_valid.
          if (err_next) begin
            res_bin <= 8'h00;
            res_inv <= 1'b1;
            res_ovf <= 1'b0;
          end else if (acc_next > 10'd255) begin
            res_bin <= 8'hFF;
            res_inv <= 1'b0;
            res_ovf <= 1'b1;
          end else begin
            res_bin <= acc_next[7:0];
            res_inv <= 1'b0;
            res_ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = (state == DONE);
  assign bus.binary_out   = res_bin;
  assign bus.err_invalid  = res_inv;
  assign bus.err_overflow = res_ovf;
  assign dbg_state        = state;

endmodule

// File: tb/tb_seven_seg_to_binary.sv
// Directed bench for seven_seg_to_binary: driver pushes expected results,
// a monitor pops and compares on every accepted output.
module tb_seven_seg_to_binary;
  import seg7_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seven_seg_to_binary_if bus ();

  seven_seg_to_binary dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Expected entry layout: {binary_out, err_invalid, err_overflow}
  logic [9:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o,
                      input logic [9:0] e);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    bus.seg_hundreds = h;
    bus.seg_tens     = t;
    bus.seg_ones     = o;
    bus.in_valid     = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b1;
    bus.seg_hundreds = 7'h00;
    bus.seg_tens     = 7'h00;
    bus.seg_ones     = 7'h00;

    // Monitor: samples 2 time units after each falling edge.
    fork
      begin : monitor
        int   hs_cyc = 0;
        logic prev_ov = 1'b0;
        logic [9:0] e;
        forever begin
          @(negedge clk);
          #2;
          if (rst) begin
            prev_ov = 1'b0;
          end else begin
            if (bus.in_valid && bus.in_ready) hs_cyc = cyc;
            if (bus.out_valid && !prev_ov) check("latency", cyc - hs_cyc, 32'd4);
            if (bus.out_valid && bus.out_ready) begin
              if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h required=none", bus.binary_out);
              end else begin
                e = exp_q.pop_front();
                check("binary_out",   {24'd0, bus.binary_out}, {24'd0, e[9:2]});
                check("err_invalid",  {31'd0, bus.err_invalid}, {31'd0, e[1]});
                check("err_overflow", {31'd0, bus.err_overflow}, {31'd0, e[0]});
              end
            end
            prev_ov = bus.out_valid;
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_binary",    {24'd0, bus.binary_out}, 32'd0);
    check("rst_err_inv",   {31'd0, bus.err_invalid}, 32'd0);
    check("rst_err_ovf",   {31'd0, bus.err_overflow}, 32'd0);
    check("rst_state",     {29'd0, dbg_state}, {29'd0, IDLE});
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Main directed vectors, back to back with out_ready high
    send(7'h5B, 7'h4F, 7'h6D, {8'hEB, 2'b00});  // 235
    send(7'h5B, 7'h6D, 7'h6D, {8'hFF, 2'b00});  // 255
    send(7'h5B, 7'h6D, 7'h7D, {8'hFF, 2'b01});  // 256
    send(7'h6F, 7'h6F, 7'h6F, {8'hFF, 2'b01});  // 999
    send(7'h5B, 7'h01, 7'h6D, {8'h00, 2'b10});  // illegal tens
    send(7'h00, 7'h00, 7'h7F, {8'h08, 2'b00});  // blanks then 8
    send(7'h3F, 7'h3F, 7'h3F, {8'h00, 2'b00});  // 000
    send(7'h01, 7'h6F, 7'h6F, {8'h00, 2'b10});  // illegal beats overflow
    drain();

    // Back-pressure hold with in_valid high and changing patterns
    bus.out_ready = 1'b0;
    send(7'h06, 7'h5B, 7'h7F, {8'h80, 2'b00});  // 128
    begin
      int n = 0;
      while (!bus.out_valid && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("hold_wait_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid     = 1'b1;
      bus.seg_hundreds = 7'($urandom_range(0, 127));
      bus.seg_tens     = 7'($urandom_range(0, 127));
      bus.seg_ones     = 7'($urandom_range(0, 127));
      #1;
      check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_in_ready",  {31'd0, bus.in_ready}, 32'd0);
      check("hold_binary",    {24'd0, bus.binary_out}, 32'h80);
      check("hold_err_inv",   {31'd0, bus.err_invalid}, 32'd0);
      check("hold_err_ovf",   {31'd0, bus.err_overflow}, 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("release_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    drain();

    // Reset while in DIG_T aborts the conversion
    @(negedge clk);
    bus.seg_hundreds = 7'h5B;
    bus.seg_tens     = 7'h4F;
    bus.seg_ones     = 7'h6D;
    bus.in_valid     = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("abort_in_dig_t", {29'd0, dbg_state}, {29'd0, DIG_T});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("abort_no_output", {31'd0, bus.out_valid}, 32'd0);
    send(7'h00, 7'h66, 7'h5B, {8'h2A, 2'b00});  // 042
    drain();

    // Reset together with a handshake: nothing is captured
    @(negedge clk);
    rst              = 1'b1;
    bus.in_valid     = 1'b1;
    bus.seg_hundreds = 7'h06;
    bus.seg_tens     = 7'h06;
    bus.seg_ones     = 7'h06;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("rst_hs_state",    {29'd0, dbg_state}, {29'd0, IDLE});
    check("rst_hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (6) @(negedge clk);
    #1;
    check("rst_hs_no_output", {31'd0, bus.out_valid}, 32'd0);

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
